ones_count_scheduler: RTL and testbench

Shares a single combinational 127-bit ones counter between NREQ requesters. Each requester presents a 127-bit word; the scheduler grants one requester at a time in round-robin order and latches that word into an operand register. The operand register drives the counter, and the scheduler returns the 7-bit population count with the requester ID over a valid/ready handshake. It sits between the client blocks and the ones-counter datapath and is the only block that drives that datapath.

---
 rtl/ones_count_scheduler_pkg.sv | 23 ++
 rtl/ones_count_scheduler_if.sv | 50 +++++
 rtl/ones_count_scheduler_one_counter.sv | 25 ++
 rtl/ones_count_scheduler.sv | 127 ++++++++++++
 tb/tb_ones_count_scheduler.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ones_count_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ones_sched_pkg
// Purpose : Shared constants and types for the ones-count scheduler slice:
//           word width, count width, accumulator width and the FSM encoding.
// Ports   : none (package)
// Config  : ONES_SCHED_ACCUM_EN (consumed by the interface and the top)
// Rev     : 1.0  initial release
// ============================================================================
package ones_sched_pkg;

  localparam int DATA_W = 127;
  localparam int CNT_W  = 7;
  localparam int ACC_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : ones_sched_pkg
`default_nettype wire

// File: rtl/ones_count_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : ones_count_scheduler_if
// Purpose : Request/grant bundle from NREQ clients plus the valid/ready result
//           channel of the ones-count scheduler.
// Ports   : req, data, grant         - client side
//           res_valid/id/count/ready - result handshake
//           acc_clr, acc_total       - accumulator (ONES_SCHED_ACCUM_EN only)
// Modports: master - clients/consumer, slave - the scheduler
// Rev     : 1.0  initial release
// ============================================================================
interface ones_count_scheduler_if
  import ones_sched_pkg::*;
#(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]        req;
  logic [NREQ*DATA_W-1:0] data;
  logic [NREQ-1:0]        grant;
  logic                   res_valid;
  logic [IDW-1:0]         res_id;
  logic [CNT_W-1:0]       res_count;
  logic                   res_ready;
`ifdef ONES_SCHED_ACCUM_EN
  logic                   acc_clr;
  logic [ACC_W-1:0]       acc_total;
`endif

  modport master (
`ifdef ONES_SCHED_ACCUM_EN
    output acc_clr,
    input  acc_total,
`endif
    output req, data, res_ready,
    input  grant, res_valid, res_id, res_count
  );

  modport slave (
`ifdef ONES_SCHED_ACCUM_EN
    input  acc_clr,
    output acc_total,
`endif
    input  req, data, res_ready,
    output grant, res_valid, res_id, res_count
  );

endinterface : ones_count_scheduler_if
`default_nettype wire

// File: rtl/ones_count_scheduler_one_counter.sv
`default_nettype none
// ============================================================================
// Module  : one_counter_127bit
// Purpose : Combinational population count of a 127-bit word.
// Ports   : data_in [126:0] in  - word to count
//           count   [6:0]   out - number of set bits, 0..127
// Rev     : 1.0  initial release
// ============================================================================
module one_counter_127bit
  import ones_sched_pkg::*;
(
  input  wire logic [DATA_W-1:0] data_in,
  output logic      [CNT_W-1:0]  count
);

  // 127 ones fit exactly in 7 bits, so the running sum never wraps.
  always_comb begin
    count = '0;
    for (int i = 0; i < DATA_W; i++) begin
      count = count + CNT_W'(data_in[i]);
    end
  end

endmodule : one_counter_127bit
`default_nettype wire

// File: rtl/ones_count_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : ones_count_scheduler
// Purpose : Round-robin arbiter sharing one 127-bit ones counter between NREQ
//           requesters. The granted word is latched into an operand register
//           that alone drives the counter; the count and requester ID are
//           returned over a valid/ready handshake.
// Ports   : clk          in  - clock, rising edge
//           rst_n        in  - asynchronous active-low reset
//           bus (slave)      - req/data/grant and result channel
// Config  : ONES_SCHED_ACCUM_EN - adds acc_clr/acc_total, a saturating sum of
//           accepted counts
// Rev     : 1.0  initial release
// ============================================================================
module ones_count_scheduler
  import ones_sched_pkg::*;
#(
  parameter int NREQ = 4
)(
  input  wire logic             clk,
  input  wire logic             rst_n,
  ones_count_scheduler_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  state_t           r_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_id_q;
  logic [DATA_W-1:0] r_operand;
  logic [NREQ-1:0]  r_grant;
  logic             r_res_valid;
  logic [IDW-1:0]   r_res_id;
  logic [CNT_W-1:0] r_res_count;

  logic [IDW-1:0]   w_pick;
  logic [IDW-1:0]   w_next_ptr;
  logic [CNT_W-1:0] w_count;

  // First set request at or after ptr, wrapping. Scanning the offsets from
  // the far end down lets the nearest hit overwrite the others.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IDW-1:0]  ptr);
    logic [IDW-1:0] pick;
    int             idx;
    pick = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (r[idx]) pick = IDW'(idx);
    end
    return pick;
  endfunction

  assign w_pick     = rr_pick(bus.req, r_rr_ptr);
  assign w_next_ptr = IDW'((int'(w_pick) + 1) % NREQ);

  one_counter_127bit u_one_counter (
    .data_in (r_operand),
    .count   (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_id_q      <= '0;
      r_operand   <= '0;
      r_grant     <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_count <= '0;
    end else begin
      r_grant <= '0;  // grant is a single-cycle pulse
      case (r_state)
        IDLE: begin
          if (|bus.req) begin
            r_operand        <= bus.data[DATA_W*w_pick +: DATA_W];
            r_id_q           <= w_pick;
            r_grant[w_pick]  <= 1'b1;
            r_rr_ptr         <= w_next_ptr;
            r_state          <= COUNT;
          end
        end
        COUNT: begin
          r_res_count <= w_count;
          r_res_id    <= r_id_q;
          r_res_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.res_valid = r_res_valid;
  assign bus.res_id    = r_res_id;
  assign bus.res_count = r_res_count;

`ifdef ONES_SCHED_ACCUM_EN
  logic [ACC_W-1:0] r_acc_total;
  logic [ACC_W:0]   w_acc_sum;

  // One extra bit catches the carry that signals saturation.
  assign w_acc_sum = {1'b0, r_acc_total} + (ACC_W + 1)'(r_res_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_total <= '0;
    end else if (bus.acc_clr) begin
      r_acc_total <= '0;  // clear wins over a coincident accept
    end else if (r_res_valid && bus.res_ready) begin
      r_acc_total <= w_acc_sum[ACC_W] ? {ACC_W{1'b1}} : w_acc_sum[ACC_W-1:0];
    end
  end

  assign bus.acc_total = r_acc_total;
`endif

endmodule : ones_count_scheduler
`default_nettype wire

// File: tb/tb_ones_count_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_ones_count_scheduler
// Purpose : Self-checking bench for ones_count_scheduler. A transaction-level
//           model predicts grant/result/accumulator outputs every cycle;
//           directed tests add literal expectations for reset, extremes,
//           fairness, backpressure and mid-transaction reset.
// Config  : ONES_SCHED_ACCUM_EN enables the accumulator tests
// Rev     : 1.0  initial release
// ============================================================================
module tb_ones_count_scheduler;
  import ones_sched_pkg::*;

  localparam int NREQ = 4;

  logic clk;
  logic rst_n;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  ones_count_scheduler_if #(.NREQ(NREQ)) bus ();

  ones_count_scheduler #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- transaction-level model ----------------
  // m_phase counts where the current transaction is: 0 free, 1 word captured,
  // 2 result on offer.
  int          m_phase;
  int          m_ptr;
  logic [3:0]  m_grant;
  logic        m_valid;
  int          m_id, m_id_pend;
  int          m_cnt, m_cnt_pend;
  int          m_acc;

  function automatic int first_req(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_ptr <= 0; m_grant <= '0; m_valid <= 1'b0;
      m_id <= 0; m_id_pend <= 0; m_cnt <= 0; m_cnt_pend <= 0; m_acc <= 0;
    end else begin
      int k;
      m_grant <= '0;
      k = first_req(bus.req, m_ptr);
      if (m_phase == 0 && k >= 0) begin
        m_grant    <= 4'(1 << k);
        m_id_pend  <= k;
        m_cnt_pend <= $countones(bus.data[DATA_W*k +: DATA_W]);
        m_ptr      <= (k + 1) % NREQ;
        m_phase    <= 1;
      end else if (m_phase == 1) begin
        m_valid <= 1'b1; m_id <= m_id_pend; m_cnt <= m_cnt_pend; m_phase <= 2;
      end else if (m_phase == 2 && bus.res_ready) begin
        m_valid <= 1'b0; m_phase <= 0;
      end
`ifdef ONES_SCHED_ACCUM_EN
      if (bus.acc_clr) m_acc <= 0;
      else if (m_valid && bus.res_ready)
        m_acc <= (m_acc + m_cnt > 65535) ? 65535 : m_acc + m_cnt;
`endif
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("grant", 32'(bus.grant), 32'(m_grant));
      check("res_valid", 32'(bus.res_valid), 32'(m_valid));
      check("res_id", 32'(bus.res_id), 32'(m_id));
      check("res_count", 32'(bus.res_count), 32'(m_cnt));
`ifdef ONES_SCHED_ACCUM_EN
      check("acc_total", 32'(bus.acc_total), 32'(m_acc));
`endif
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_grant(input logic [3:0] exp, input int budget, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.grant == '0 && waited < budget);
    check("grant_literal", 32'(bus.grant), 32'(exp));
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.res_valid && n < budget);
    check("valid_seen", 32'(bus.res_valid), 32'd1);
  endtask

  task automatic do_single(input int idx, input logic [DATA_W-1:0] word, input int exp_cnt);
    int w;
    bus.data[DATA_W*idx +: DATA_W] = word;
    bus.req = 4'(1 << idx);
    wait_grant(4'(1 << idx), 10, w);
    #1 bus.req = '0;
    wait_valid(10);
    check("single_id", 32'(bus.res_id), 32'(idx));
    check("single_count", 32'(bus.res_count), 32'(exp_cnt));
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DATA_W-1:0] w;
    int                wt;
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.data      = '0;
    bus.res_ready = 1'b0;
`ifdef ONES_SCHED_ACCUM_EN
    bus.acc_clr   = 1'b0;
`endif
    @(posedge clk); #1 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_valid", 32'(bus.res_valid), 32'd0);
    check("rst_id", 32'(bus.res_id), 32'd0);
    check("rst_count", 32'(bus.res_count), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    bus.res_ready = 1'b1;

    // First request, zero word, requester 2
    do_single(2, '0, 0);

    // Extremes
    do_single(0, '1, 127);
    w = '0; w[0] = 1'b1;
    do_single(1, w, 1);
    w = '0; w[126] = 1'b1;
    do_single(1, w, 1);

    // Reset while the word is being counted
    bus.data = '1;
    bus.req = 4'b1000;
    wait_grant(4'b1000, 10, wt);
    #1 rst_n = 1'b0; bus.req = '0;
    repeat (4) begin
      @(negedge clk);
      check("rst_mid_valid", 32'(bus.res_valid), 32'd0);
    end
    @(posedge clk); #2 rst_n = 1'b1;

    // Fairness: grant order restarts at 0 after reset
    bus.req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      wait_grant(4'(1 << (i % 4)), 10, wt);
      if (i > 0) check("grant_spacing", 32'(wt), 32'd3);
    end
    #1 bus.req = '0;
    repeat (3) @(negedge clk);

    // Backpressure: requester 2, low 100 bits set
    w = '0;
    for (int i = 0; i < 100; i++) w[i] = 1'b1;
    bus.data[DATA_W*2 +: DATA_W] = w;
    bus.res_ready = 1'b0;
    bus.req = 4'b0100;
    wait_grant(4'b0100, 10, wt);
    #1 bus.req = 4'hF;
    wait_valid(10);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.res_valid), 32'd1);
      check("bp_id", 32'(bus.res_id), 32'd2);
      check("bp_count", 32'(bus.res_count), 32'd100);
      check("bp_no_grant", 32'(bus.grant), 32'd0);
    end
    #1 bus.res_ready = 1'b1; bus.req = '0;
    @(negedge clk);
    check("bp_release", 32'(bus.res_valid), 32'd0);
    @(negedge clk);

    // Mixed traffic judged by the model alone
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #2;
      bus.req = 4'($urandom_range(0, 15));
      bus.res_ready = 1'($urandom_range(0, 1));
      if ((c % 7) == 0)
        for (int i = 0; i < NREQ; i++)
          bus.data[DATA_W*i +: DATA_W] = {$urandom, $urandom, $urandom, $urandom};
    end
    bus.req = '0; bus.res_ready = 1'b1;
    repeat (4) @(negedge clk);

`ifdef ONES_SCHED_ACCUM_EN
    begin
      int accepts = 0;
      int cyc = 0;
      #1 bus.acc_clr = 1'b1;
      @(negedge clk); #1 bus.acc_clr = 1'b0;
      bus.data = '1;
      bus.req = 4'b0001;
      while (accepts < 600 && cyc < 3000) begin
        @(negedge clk);
        cyc++;
        if (bus.res_valid && bus.res_ready) accepts++;
      end
      check("acc_accepts", 32'(accepts), 32'd600);
      #1 bus.req = '0;
      @(negedge clk);
      check("acc_saturated", 32'(bus.acc_total), 32'h0000FFFF);
      bus.req = 4'b0001;
      wait_valid(10);
      #1 bus.acc_clr = 1'b1; bus.req = '0;
      @(negedge clk);
      check("acc_clr_priority", 32'(bus.acc_total), 32'd0);
      #1 bus.acc_clr = 1'b0;
      repeat (2) @(negedge clk);
    end
`endif

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_ones_count_scheduler
`default_nettype wire
